// File: rtl/bcd_encode.sv
// bcd_encode: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A start/busy/done handshake frames each conversion. bcd and overflow are
// registered and change only on the completion edge, holding the last result
// otherwise, so the display path never sees intermediate digits.
module bcd_encode #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [WIDTH-1:0] bin_r, bin_s;
  logic [AW-1:0]   acc_r, acc_s;
  logic [AW-1:0]   adj_s;
  logic            ovf_r, ovf_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            busy_s, done_s, overflow_s;
  logic [AW-1:0]   bcd_s;

  // Per-digit correction: any digit >= 5 gets 3 added, wrapping inside the
  // nibble so nothing carries into the neighbouring digit.
  function automatic logic [AW-1:0] add3_digits(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    logic [3:0]    d;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = a[4*i +: 4];
      if (d >= 4'd5) begin
        r[4*i +: 4] = d + 4'd3;
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  // Next-state and datapath: capture on start, then correct-and-shift each cycle.
  always_comb begin
    state_s    = state_r;
    bin_s      = bin_r;
    acc_s      = acc_r;
    ovf_s      = ovf_r;
    cnt_s      = cnt_r;
    busy_s     = busy;
    done_s     = 1'b0;
    bcd_s      = bcd;
    overflow_s = overflow;
    adj_s      = add3_digits(acc_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          bin_s   = value;
          acc_s   = '0;
          ovf_s   = 1'b0;
          cnt_s   = '0;
          busy_s  = 1'b1;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        // MSB of bin enters the bottom of acc; the top bit of the corrected acc
        // falls off and is remembered as overflow.
        acc_s = {adj_s[AW-2:0], bin_r[WIDTH-1]};
        bin_s = bin_r << 1;
        ovf_s = ovf_r | adj_s[AW-1];
        cnt_s = cnt_r + CW'(1);
        if (cnt_r == CW'(WIDTH - 1)) begin
          bcd_s      = acc_s;
          overflow_s = ovf_s;
          done_s     = 1'b1;
          busy_s     = 1'b0;
          state_s    = IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs; async reset abandons any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      bin_r    <= '0;
      acc_r    <= '0;
      ovf_r    <= 1'b0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      state_r  <= state_s;
      bin_r    <= bin_s;
      acc_r    <= acc_s;
      ovf_r    <= ovf_s;
      cnt_r    <= cnt_s;
      busy     <= busy_s;
      done     <= done_s;
      bcd      <= bcd_s;
      overflow <= overflow_s;
    end
  end

endmodule

// File: tb/tb_bcd_encode.sv
// tb_bcd_encode: directed checks of bcd_encode with a 3-digit and a 2-digit
// instance driven from the same stimulus.
module tb_bcd_encode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  value;
  logic        busy, done, overflow;
  logic [11:0] bcd;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcd2;

  int errors = 0;
  int checks = 0;

  // 10 ns clock
  always #5 clk = ~clk;

  bcd_encode #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  bcd_encode #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic digits_ok(input logic [11:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
  endfunction

  // Start a conversion, check latency/busy span/single-cycle done; ends after the cycle following done.
  task automatic convert(input logic [7:0] v, input string tag);
    int lat;
    int bcyc;
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    value = ~v;
    lat  = 1;
    bcyc = busy ? 1 : 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
    end
    check({tag, " done_edge"}, 32'(lat), 32'd9);
    check({tag, " busy_cycles"}, 32'(bcyc), 32'd8);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    int iv;
    logic [11:0] expb;

    rst_n = 1'b0;
    start = 1'b0;
    value = 8'd0;
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst bcd", 32'(bcd), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(8'd0, "v0");
    check("v0 bcd", 32'(bcd), 32'h000);
    check("v0 ovf", 32'(overflow), 32'd0);
    convert(8'd255, "v255");
    check("v255 bcd", 32'(bcd), 32'h255);
    check("v255 ovf", 32'(overflow), 32'd0);
    check("v255 d2 ovf", 32'(overflow2), 32'd1);
    convert(8'd99, "v99");
    check("v99 bcd", 32'(bcd), 32'h099);
    check("v99 d2 bcd", 32'(bcd2), 32'h99);
    check("v99 d2 ovf", 32'(overflow2), 32'd0);
    convert(8'd200, "v200");
    check("v200 bcd", 32'(bcd), 32'h200);
    check("v200 d2 ovf", 32'(overflow2), 32'd1);
    convert(8'd100, "v100");
    check("v100 bcd", 32'(bcd), 32'h100);
    check("v100 d2 ovf", 32'(overflow2), 32'd1);
    check("v100 d2 done", 32'(done2), 32'd0);

    for (int v = 0; v < 256; v++) begin
      iv   = v;
      expb = {4'(iv / 100), 4'((iv / 10) % 10), 4'(iv % 10)};
      convert(8'(v), "sweep");
      check("sweep bcd", 32'(bcd), 32'(expb));
      check("sweep ovf", 32'(overflow), 32'd0);
      check("sweep digits", 32'(digits_ok(bcd)), 32'd1);
    end

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1;
    value = 8'd37;
    @(negedge clk);
    start = 1'b0;
    value = 8'd0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    value = 8'd180;
    @(negedge clk);
    start = 1'b0;
    value = 8'd0;
    check("ign busy", 32'(busy), 32'd1);
    lat = 4;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign done_edge", 32'(lat), 32'd9);
    check("ign bcd", 32'(bcd), 32'h037);

    // Start held in the done cycle is accepted at the next edge.
    start = 1'b1;
    value = 8'd180;
    @(negedge clk);
    check("hold busy", 32'(busy), 32'd1);
    check("hold done", 32'(done), 32'd0);
    start = 1'b0;
    value = 8'd0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("hold done_edge", 32'(lat), 32'd9);
    check("hold bcd", 32'(bcd), 32'h180);
    @(negedge clk);
    check("hold done_pulse", 32'(done), 32'd0);

    // Asynchronous reset mid-conversion.
    start = 1'b1;
    value = 8'd255;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst done", 32'(done), 32'd0);
    check("arst bcd", 32'(bcd), 32'd0);
    check("arst ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("arst no_done", 32'(seen), 32'd0);
    convert(8'd12, "v12");
    check("v12 bcd", 32'(bcd), 32'h012);
    check("v12 ovf", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
